// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: recovers pixel timing from a VGA sync/rgb bus and checks geometry.
// Optional frame CRC output enabled by defining VGA_RX_CRC_EN.
module vga_rx_monitor #(
   parameter int   H_ACTIVE    = 640,
   parameter int   H_FP        = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BP        = 48,
   parameter int   V_ACTIVE    = 480,
   parameter int   V_FP        = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BP        = 33,
   parameter logic SYNC_POL    = 1'b0,
   parameter int   PIX_DIV     = 4,
   parameter int   LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [3:0]  red,
   input  logic [3:0]  green,
   input  logic [3:0]  blue,
   output logic        locked,
   output logic        frame_start,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [11:0] pix_rgb,
   output logic        line_err,
   output logic        frame_err,
   output logic [15:0] err_cnt,
`ifdef VGA_RX_CRC_EN
   output logic [15:0] frame_crc,
`endif
   output logic [11:0] meas_htotal,
   output logic [11:0] meas_vtotal
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [7:0]  DIV_LAST = 8'(PIX_DIV - 1);
   localparam logic [7:0]  DIV_MID  = 8'(PIX_DIV / 2);
   localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);
   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] H_SW     = 12'(H_SYNC);
   localparam logic [11:0] V_TOT    = 12'(V_TOTAL);
   localparam logic [11:0] V_SW     = 12'(V_SYNC);
   localparam logic [11:0] H_LO     = 12'(H_SYNC + H_BP);
   localparam logic [11:0] H_HI     = 12'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [11:0] V_LO     = 12'(V_SYNC + V_BP);
   localparam logic [11:0] V_HI     = 12'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [9:0]  H_LO10   = 10'(H_SYNC + H_BP);
   localparam logic [9:0]  V_LO10   = 10'(V_SYNC + V_BP);
   localparam logic [12:0] WD_MAX   = 13'(2 * H_TOTAL - 1);

   typedef enum logic [1:0] {SEARCH, TRACK, LOCK} state_t;

   state_t      state, state_nxt;
   logic [7:0]  gcnt, gcnt_nxt;
   logic        ferr_ev;

   logic        hs_a, hs_d, vs_a;
   logic [11:0] rgb_r;
   logic [7:0]  div;
   logic [11:0] hcnt, vcnt, vw;
   logic [12:0] wd;
   logic        h_first, seen_h, v_prev, lerr_seen;

   logic        h_rise, h_fall, tick, wd_hit, fs_ev;
   logic        lerr_ev, bad, in_act;
   logic [11:0] pidx;
   logic [9:0]  x, y;

   assign h_rise = hs_a & ~hs_d;
   assign h_fall = ~hs_a & hs_d;
   assign tick   = (div == DIV_MID);
   assign wd_hit = tick & ~h_rise & seen_h & (wd == WD_MAX);
   assign fs_ev  = h_rise & vs_a & ~v_prev;

   // Index of the pixel sampled on this tick; the first tick after an edge is pixel 0.
   assign pidx = h_first ? 12'd0 : hcnt + 12'd1;
   assign x    = pidx[9:0] - H_LO10;
   assign y    = vcnt[9:0] - V_LO10;

   assign in_act = tick & ~h_rise & (state != SEARCH)
                 & (pidx >= H_LO) & (pidx < H_HI)
                 & (vcnt >= V_LO) & (vcnt < V_HI);

   always_comb begin
      lerr_ev = 1'b0;
      if (h_rise && seen_h && hcnt != H_LAST) lerr_ev = 1'b1;
      if (h_fall && seen_h && pidx != H_SW)   lerr_ev = 1'b1;
      if (wd_hit)                             lerr_ev = 1'b1;
   end

   assign bad = (vcnt + 12'd1 != V_TOT) | (vw != V_SW)
              | lerr_seen | lerr_ev;

   always_comb begin
      state_nxt = state;
      gcnt_nxt  = gcnt;
      ferr_ev   = 1'b0;
      if (wd_hit) begin
         state_nxt = SEARCH;
         gcnt_nxt  = 8'd0;
      end else if (fs_ev) begin
         unique case (state)
            SEARCH: begin
               state_nxt = TRACK;
               gcnt_nxt  = 8'd0;
            end
            TRACK: begin
               if (bad) begin
                  gcnt_nxt = 8'd0;
                  ferr_ev  = 1'b1;
               end else begin
                  gcnt_nxt = gcnt + 8'd1;
                  if (gcnt + 8'd1 == LOCK_N) state_nxt = LOCK;
               end
            end
            LOCK: begin
               if (bad) begin
                  state_nxt = TRACK;
                  gcnt_nxt  = 8'd0;
                  ferr_ev   = 1'b1;
               end
            end
            default: state_nxt = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= SEARCH;
         gcnt  <= 8'd0;
      end else begin
         state <= state_nxt;
         gcnt  <= gcnt_nxt;
      end
   end

   assign locked = (state == LOCK);

   always_ff @(posedge clk) begin
      if (!rst) begin
         hs_a        <= 1'b0;
         hs_d        <= 1'b0;
         vs_a        <= 1'b0;
         rgb_r       <= '0;
         div         <= '0;
         hcnt        <= '0;
         vcnt        <= '0;
         vw          <= '0;
         wd          <= '0;
         h_first     <= 1'b0;
         seen_h      <= 1'b0;
         v_prev      <= 1'b0;
         lerr_seen   <= 1'b0;
         line_err    <= 1'b0;
         frame_err   <= 1'b0;
         frame_start <= 1'b0;
         err_cnt     <= '0;
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_rgb     <= '0;
         meas_htotal <= '0;
         meas_vtotal <= '0;
      end else begin
         hs_a  <= (hsync == SYNC_POL);
         hs_d  <= hs_a;
         vs_a  <= (vsync == SYNC_POL);
         rgb_r <= {red, green, blue};

         if (h_rise || div == DIV_LAST) div <= '0;
         else                           div <= div + 8'd1;

         if (h_rise) begin
            hcnt    <= '0;
            h_first <= 1'b1;
         end else if (tick) begin
            hcnt    <= pidx;
            h_first <= 1'b0;
         end

         if (h_rise || wd_hit)         wd <= '0;
         else if (tick && wd != WD_MAX) wd <= wd + 13'd1;

         if (wd_hit)      seen_h <= 1'b0;
         else if (h_rise) seen_h <= 1'b1;

         // vsync level is judged on the hsync edge so coincident edges resolve cleanly
         if (h_rise) begin
            meas_htotal <= hcnt + 12'd1;
            v_prev      <= vs_a;
            if (fs_ev) begin
               vcnt        <= '0;
               vw          <= 12'd1;
               meas_vtotal <= vcnt + 12'd1;
            end else begin
               vcnt <= vcnt + 12'd1;
               if (vs_a && v_prev) vw <= vw + 12'd1;
            end
         end

         if (fs_ev)        lerr_seen <= 1'b0;
         else if (lerr_ev) lerr_seen <= 1'b1;

         line_err    <= lerr_ev;
         frame_err   <= ferr_ev;
         frame_start <= fs_ev;
         if (ferr_ev && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;

         pix_valid <= in_act;
         if (in_act) begin
            pix_x   <= x;
            pix_y   <= y;
            pix_rgb <= rgb_r;
         end
      end
   end

`ifdef VGA_RX_CRC_EN
   logic [15:0] crc;

   function automatic logic [15:0] crc_upd(input logic [15:0] c,
                                           input logic [15:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 15; i >= 0; i--) begin
         if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         crc       <= 16'hFFFF;
         frame_crc <= '0;
      end else if (fs_ev) begin
         frame_crc <= crc;
         crc       <= 16'hFFFF;
      end else if (in_act) begin
         crc <= crc_upd(crc, {4'h0, rgb_r});
      end
   end
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: directed raster stimulus for vga_rx_monitor on a reduced timing grid.
// Expected values are hand-derived from the small geometry constants below.
module tb_vga_rx_monitor;
   localparam int HA = 8, HF = 2, HS = 4, HB = 2, HT = 16;
   localparam int VA = 6, VF = 1, VS = 2, VB = 2, VT = 11;
   localparam int PD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        hsync, vsync;
   logic [3:0]  red, green, blue;
   logic        locked, frame_start, pix_valid, line_err, frame_err;
   logic [9:0]  pix_x, pix_y;
   logic [11:0] pix_rgb, meas_htotal, meas_vtotal;
   logic [15:0] err_cnt;

   int n_chk = 0, n_pass = 0;
   int n_lerr = 0, n_ferr = 0, n_pv = 0, n_fs = 0;
   bit got_first = 0;
   logic [9:0]  fx, fy, lx, ly;
   logic [11:0] frgb, lrgb;

   vga_rx_monitor #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0), .PIX_DIV(PD), .LOCK_FRAMES(2)
   ) dut (
      .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
      .red(red), .green(green), .blue(blue),
      .locked(locked), .frame_start(frame_start),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .pix_rgb(pix_rgb), .line_err(line_err), .frame_err(frame_err),
      .err_cnt(err_cnt), .meas_htotal(meas_htotal),
      .meas_vtotal(meas_vtotal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (line_err)    n_lerr++;
      if (frame_err)   n_ferr++;
      if (frame_start) n_fs++;
      if (pix_valid) begin
         n_pv++;
         if (!got_first) begin
            got_first = 1;
            fx = pix_x; fy = pix_y; frgb = pix_rgb;
         end
         lx = pix_x; ly = pix_y; lrgb = pix_rgb;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                    tag, got, got, exp, exp);
   endtask

   function automatic logic [11:0] rgb_of(input int l, input int p);
      int x, y;
      x = p - (HS + HB);
      y = l - (VS + VB);
      if (x < 0 || x >= HA || y < 0 || y >= VA) return 12'h000;
      if (x == 0) return 12'h5A0 | 12'(y);
      return 12'hF0A;
   endfunction

   task automatic line(input int l, input int len, input int sw);
      for (int p = 0; p < len; p++) begin
         hsync = (p < sw) ? 1'b0 : 1'b1;
         vsync = (l < VS) ? 1'b0 : 1'b1;
         {red, green, blue} = rgb_of(l, p);
         repeat (PD) @(negedge clk);
      end
   endtask

   task automatic lines(input int l0, input int l1);
      for (int l = l0; l < l1; l++) line(l, HT, HS);
   endtask

   task automatic frame();
      lines(0, VT);
   endtask

   task automatic idle(input int n);
      hsync = 1'b1; vsync = 1'b1; {red, green, blue} = 12'h000;
      repeat (n * PD) @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_locked"}, locked, 0);
      chk({tag, "_fs"},     frame_start, 0);
      chk({tag, "_pv"},     pix_valid, 0);
      chk({tag, "_lerr"},   line_err, 0);
      chk({tag, "_ferr"},   frame_err, 0);
      chk({tag, "_errcnt"}, err_cnt, 0);
      chk({tag, "_htot"},   meas_htotal, 0);
      chk({tag, "_vtot"},   meas_vtotal, 0);
      chk({tag, "_pixrgb"}, pix_rgb, 0);
   endtask

   initial begin
      rst = 1'b0; hsync = 1'b1; vsync = 1'b1;
      red = 4'h0; green = 4'h0; blue = 4'h0;
      repeat (3) @(negedge clk);
      chk_reset("rst0");
      rst = 1'b1;
      idle(2);

      // nominal raster: lock after two judged frames
      frame();
      n_pv = 0; n_fs = 0;
      frame();
      chk("pv_per_frame", n_pv, HA * VA);
      chk("fs_per_frame", n_fs, 1);
      chk("first_x", fx, 0);
      chk("first_y", fy, 0);
      chk("first_rgb", frgb, 12'h5A0);
      chk("last_x", lx, HA - 1);
      chk("last_y", ly, VA - 1);
      chk("last_rgb", lrgb, 12'hF0A);
      chk("lock_f2", locked, 0);
      frame();
      chk("lock_f3", locked, 1);
      chk("htot_nom", meas_htotal, HT);
      chk("vtot_nom", meas_vtotal, VT);
      chk("errcnt_nom", err_cnt, 0);
      chk("lerr_nom", n_lerr, 0);
      chk("ferr_nom", n_ferr, 0);

      // one long line while locked
      n_lerr = 0; n_ferr = 0;
      lines(0, 6);
      line(6, HT + 1, HS);
      line(7, HT, HS);
      chk("htot_long", meas_htotal, HT + 1);
      chk("lerr_long", n_lerr, 1);
      lines(8, VT);
      chk("lock_long_pending", locked, 1);
      chk("ferr_long_pending", n_ferr, 0);
      frame();
      chk("ferr_long", n_ferr, 1);
      chk("lock_long_lost", locked, 0);
      chk("errcnt_long", err_cnt, 1);
      chk("lerr_long_once", n_lerr, 1);
      frame();
      chk("relock_wait", locked, 0);
      frame();
      chk("relock", locked, 1);

      // narrow hsync pulse on one line
      n_lerr = 0; n_ferr = 0;
      lines(0, 7);
      line(7, HT, HS - 1);
      lines(8, VT);
      chk("lerr_narrow", n_lerr, 1);
      chk("lock_narrow_pending", locked, 1);
      frame();
      chk("ferr_narrow", n_ferr, 1);
      chk("errcnt_narrow", err_cnt, 2);
      chk("lock_narrow_lost", locked, 0);

      // short frame
      n_ferr = 0;
      lines(0, VT - 1);
      frame();
      chk("vtot_short", meas_vtotal, VT - 1);
      chk("ferr_short", n_ferr, 1);
      chk("errcnt_short", err_cnt, 3);

      // hsync loss trips the watchdog back to search
      n_lerr = 0; n_ferr = 0; n_pv = 0;
      idle(40);
      chk("lerr_wdog", n_lerr, 1);
      lines(4, VT);
      chk("pv_search", n_pv, 0);
      chk("lock_search", locked, 0);
      n_pv = 0;
      frame();
      chk("ferr_search", n_ferr, 0);
      chk("pv_retrack", n_pv, HA * VA);
      frame();
      frame();
      chk("lock_after_wdog", locked, 1);
      chk("errcnt_after_wdog", err_cnt, 3);

      // one-clock reset mid-frame while locked
      n_ferr = 0;
      lines(0, 6);
      fork
         line(6, HT, HS);
         begin
            repeat (20) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk_reset("rst_mid");
            rst = 1'b1;
         end
      join
      lines(7, VT);
      chk("lock_rst_search", locked, 0);
      frame();
      chk("lock_rst_f1", locked, 0);
      frame();
      chk("lock_rst_f2", locked, 0);
      frame();
      chk("lock_rst_f3", locked, 1);
      chk("ferr_rst", n_ferr, 0);
      chk("errcnt_rst", err_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
